// File: rtl/wb_arbiter_pkg.sv
// wb_arbiter_pkg: shared widths, write-back grant source encodings and JTAG
// handshake states for the write-back arbiter and its holding slots.
package wb_arbiter_pkg;

   localparam int REG_ADDR_WIDTH = 5;
   localparam int CPU_WIDTH      = 32;
   localparam int STARVE_LIMIT   = 4;

   // Source of the write granted in the current cycle.
   typedef enum logic [2:0] {
      WB_SRC_NONE,
      WB_SRC_ALU,
      WB_SRC_LSU,
      WB_SRC_DIV,
      WB_SRC_JTAG
   } wb_src_e;

   // JTAG handshake: ACK is the cycle the committed write and ack pulse are
   // on the outputs, BLANK is the following cycle in which req is ignored.
   typedef enum logic [1:0] {
      JTAG_IDLE,
      JTAG_ACK,
      JTAG_BLANK
   } jtag_state_e;

   // Only slot writes retire scoreboard entries.
   function automatic logic src_is_slot(input wb_src_e src);
      return (src == WB_SRC_LSU) || (src == WB_SRC_DIV);
   endfunction

endpackage

// File: rtl/wb_arbiter_slot.sv
// wb_arbiter_slot: one-entry valid/ready holding register for a long-latency
// result (LSU or DIV).
//   clk, rst_n           clock, async active-low reset
//   valid, in_addr/data  producer side; captured on valid & ready
//   ready                ~full, straight from the register (no valid->ready path)
//   drain                arbiter grant; empties the slot at the edge
//   full, addr, data     held entry presented to the arbiter
module wb_arbiter_slot
   import wb_arbiter_pkg::*;
#(
   parameter int AW = REG_ADDR_WIDTH,
   parameter int DW = CPU_WIDTH
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          valid,
   input  logic [AW-1:0] in_addr,
   input  logic [DW-1:0] in_data,
   output logic          ready,
   input  logic          drain,
   output logic          full,
   output logic [AW-1:0] addr,
   output logic [DW-1:0] data
);

   assign ready = ~full;

   // Capture only when empty and drain only when full, so the two never overlap.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         full <= 1'b0;
         addr <= '0;
         data <= '0;
      end else if (valid && !full) begin
         full <= 1'b1;
         addr <= in_addr;
         data <= in_data;
      end else if (drain) begin
         full <= 1'b0;
      end
   end

endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: write-back stage merging ALU, LSU, DIV and JTAG writes into the
// single register-file write port, with a RAW busy scoreboard.
//   clk, rst_n                      clock, async active-low reset
//   alu_wr_*                        single-cycle ALU result, no backpressure
//   lsu_* / div_*                   valid/ready results, one holding slot each
//   jtag_req/addr/data, jtag_ack_o  level debug write request, one-cycle ack
//   busy_set_i/addr                 decode issued a long-latency destination
//   rs1/rs2_addr_i, rs1/rs2_busy_o  hazard lookup (combinational)
//   alu_hold_o                      registered; forces a bubble to relieve starvation
//   reg_wr_en/addr/data_o           registered register-file write port
module wb_arbiter
   import wb_arbiter_pkg::*;
#(
   parameter int REG_ADDR_WIDTH = wb_arbiter_pkg::REG_ADDR_WIDTH,
   parameter int CPU_WIDTH      = wb_arbiter_pkg::CPU_WIDTH,
   parameter int STARVE_LIMIT   = wb_arbiter_pkg::STARVE_LIMIT
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      alu_wr_en_i,
   input  logic [REG_ADDR_WIDTH-1:0] alu_wr_addr_i,
   input  logic [CPU_WIDTH-1:0]      alu_wr_data_i,
   input  logic                      lsu_valid_i,
   output logic                      lsu_ready_o,
   input  logic [REG_ADDR_WIDTH-1:0] lsu_addr_i,
   input  logic [CPU_WIDTH-1:0]      lsu_data_i,
   input  logic                      div_valid_i,
   output logic                      div_ready_o,
   input  logic [REG_ADDR_WIDTH-1:0] div_addr_i,
   input  logic [CPU_WIDTH-1:0]      div_data_i,
   input  logic                      jtag_req_i,
   input  logic [REG_ADDR_WIDTH-1:0] jtag_addr_i,
   input  logic [CPU_WIDTH-1:0]      jtag_data_i,
   output logic                      jtag_ack_o,
   input  logic                      busy_set_i,
   input  logic [REG_ADDR_WIDTH-1:0] busy_set_addr_i,
   input  logic [REG_ADDR_WIDTH-1:0] rs1_addr_i,
   input  logic [REG_ADDR_WIDTH-1:0] rs2_addr_i,
   output logic                      rs1_busy_o,
   output logic                      rs2_busy_o,
   output logic                      alu_hold_o,
   output logic                      reg_wr_en_o,
   output logic [REG_ADDR_WIDTH-1:0] reg_wr_addr_o,
   output logic [CPU_WIDTH-1:0]      reg_wr_data_o
);

   localparam int CW = $clog2(STARVE_LIMIT + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(STARVE_LIMIT - 1);

   logic                      lsu_full, div_full;
   logic [REG_ADDR_WIDTH-1:0] lsu_addr, div_addr, g_addr;
   logic [CPU_WIDTH-1:0]      lsu_data, div_data, g_data;
   wb_src_e                   src;
   jtag_state_e               jtag_state;
   logic                      jtag_ok, pending, non_alu, wr_from_slot;
   logic [CW-1:0]             cnt, cnt_inc;
   logic [(1<<REG_ADDR_WIDTH)-1:0] busy;

   wb_arbiter_slot #(.AW(REG_ADDR_WIDTH), .DW(CPU_WIDTH)) u_lsu_slot (
      .clk(clk), .rst_n(rst_n), .valid(lsu_valid_i), .in_addr(lsu_addr_i),
      .in_data(lsu_data_i), .ready(lsu_ready_o), .drain(src == WB_SRC_LSU),
      .full(lsu_full), .addr(lsu_addr), .data(lsu_data)
   );

   wb_arbiter_slot #(.AW(REG_ADDR_WIDTH), .DW(CPU_WIDTH)) u_div_slot (
      .clk(clk), .rst_n(rst_n), .valid(div_valid_i), .in_addr(div_addr_i),
      .in_data(div_data_i), .ready(div_ready_o), .drain(src == WB_SRC_DIV),
      .full(div_full), .addr(div_addr), .data(div_data)
   );

   // JTAG is only eligible while idle: not in the ack cycle (req still held)
   // nor the blanking cycle that gives the requester time to drop req.
   assign jtag_ok = jtag_req_i && (jtag_state == JTAG_IDLE);
   assign pending = lsu_full || div_full || jtag_ok;

   always_comb begin
      src    = WB_SRC_NONE;
      g_addr = '0;
      g_data = '0;
      if (alu_wr_en_i) begin
         src = WB_SRC_ALU;  g_addr = alu_wr_addr_i; g_data = alu_wr_data_i;
      end else if (lsu_full) begin
         src = WB_SRC_LSU;  g_addr = lsu_addr;      g_data = lsu_data;
      end else if (div_full) begin
         src = WB_SRC_DIV;  g_addr = div_addr;      g_data = div_data;
      end else if (jtag_ok) begin
         src = WB_SRC_JTAG; g_addr = jtag_addr_i;   g_data = jtag_data_i;
      end
   end

   assign non_alu = (src != WB_SRC_NONE) && (src != WB_SRC_ALU);
   assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CW'(1);

   // Output register; writes to x0 still drain their source but never reach the file.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         reg_wr_en_o   <= 1'b0;
         reg_wr_addr_o <= '0;
         reg_wr_data_o <= '0;
         wr_from_slot  <= 1'b0;
      end else begin
         reg_wr_en_o   <= (src != WB_SRC_NONE) && (g_addr != '0);
         reg_wr_addr_o <= g_addr;
         reg_wr_data_o <= g_data;
         wr_from_slot  <= src_is_slot(src);
      end
   end

   // JTAG handshake; the ack lines up with the committed write on reg_wr_*.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         jtag_state <= JTAG_IDLE;
         jtag_ack_o <= 1'b0;
      end else begin
         jtag_ack_o <= 1'b0;
         case (jtag_state)
            JTAG_IDLE:
               if (src == WB_SRC_JTAG) begin
                  jtag_state <= JTAG_ACK;
                  jtag_ack_o <= 1'b1;
               end
            JTAG_ACK:   jtag_state <= JTAG_BLANK;
            default:    jtag_state <= JTAG_IDLE;
         endcase
      end
   end

   // Starvation: hold the ALU for one cycle once a request has lost
   // STARVE_LIMIT-1 times in a row; the bubble hands the grant to it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt        <= '0;
         alu_hold_o <= 1'b0;
      end else begin
         if (non_alu)      cnt <= '0;
         else if (pending) cnt <= cnt_inc;
         alu_hold_o <= pending && !non_alu && (cnt_inc == CNT_MAX);
      end
   end

   // Scoreboard: clear when a slot write is on the port (the file takes it at
   // this edge); a same-edge set for the same register is applied last and wins.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy <= '0;
      end else begin
         if (reg_wr_en_o && wr_from_slot) busy[reg_wr_addr_o] <= 1'b0;
         if (busy_set_i && (busy_set_addr_i != '0)) busy[busy_set_addr_i] <= 1'b1;
      end
   end

   assign rs1_busy_o = (rs1_addr_i != '0) && busy[rs1_addr_i];
   assign rs2_busy_o = (rs2_addr_i != '0) && busy[rs2_addr_i];

endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed vectors for wb_arbiter. Stimulus pushes expected
// register-file writes into a queue; a monitor pops and compares whenever the
// DUT drives reg_wr_en_o or jtag_ack_o. Inputs change and outputs are sampled
// on the falling edge.
module tb_wb_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        alu_wr_en_i;
   logic [4:0]  alu_wr_addr_i;
   logic [31:0] alu_wr_data_i;
   logic        lsu_valid_i, lsu_ready_o;
   logic [4:0]  lsu_addr_i;
   logic [31:0] lsu_data_i;
   logic        div_valid_i, div_ready_o;
   logic [4:0]  div_addr_i;
   logic [31:0] div_data_i;
   logic        jtag_req_i, jtag_ack_o;
   logic [4:0]  jtag_addr_i;
   logic [31:0] jtag_data_i;
   logic        busy_set_i;
   logic [4:0]  busy_set_addr_i, rs1_addr_i, rs2_addr_i;
   logic        rs1_busy_o, rs2_busy_o, alu_hold_o;
   logic        reg_wr_en_o;
   logic [4:0]  reg_wr_addr_o;
   logic [31:0] reg_wr_data_o;

   typedef struct packed {
      logic [4:0]  addr;
      logic [31:0] data;
      logic        ack;
   } exp_t;

   exp_t expq[$];
   exp_t mon_e;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   wb_arbiter dut (
      .clk(clk), .rst_n(rst_n),
      .alu_wr_en_i(alu_wr_en_i), .alu_wr_addr_i(alu_wr_addr_i), .alu_wr_data_i(alu_wr_data_i),
      .lsu_valid_i(lsu_valid_i), .lsu_ready_o(lsu_ready_o), .lsu_addr_i(lsu_addr_i), .lsu_data_i(lsu_data_i),
      .div_valid_i(div_valid_i), .div_ready_o(div_ready_o), .div_addr_i(div_addr_i), .div_data_i(div_data_i),
      .jtag_req_i(jtag_req_i), .jtag_addr_i(jtag_addr_i), .jtag_data_i(jtag_data_i), .jtag_ack_o(jtag_ack_o),
      .busy_set_i(busy_set_i), .busy_set_addr_i(busy_set_addr_i),
      .rs1_addr_i(rs1_addr_i), .rs2_addr_i(rs2_addr_i), .rs1_busy_o(rs1_busy_o), .rs2_busy_o(rs2_busy_o),
      .alu_hold_o(alu_hold_o),
      .reg_wr_en_o(reg_wr_en_o), .reg_wr_addr_o(reg_wr_addr_o), .reg_wr_data_o(reg_wr_data_o)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic nc();
      @(negedge clk);
   endtask

   // Monitor: every write or ack must match the oldest expectation.
   always @(negedge clk) begin
      if (rst_n && (reg_wr_en_o || jtag_ack_o)) begin
         if (expq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write: got en %0b addr %0d data 0x%0h ack %0b, expected no write at %0t",
                     reg_wr_en_o, reg_wr_addr_o, reg_wr_data_o, jtag_ack_o, $time);
         end else begin
            mon_e = expq.pop_front();
            chk("wr_en",   {31'd0, reg_wr_en_o}, 32'd1);
            chk("wr_addr", {27'd0, reg_wr_addr_o}, {27'd0, mon_e.addr});
            chk("wr_data", reg_wr_data_o, mon_e.data);
            chk("wr_ack",  {31'd0, jtag_ack_o}, {31'd0, mon_e.ack});
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      rst_n = 1'b0;
      alu_wr_en_i = 0; alu_wr_addr_i = 0; alu_wr_data_i = 0;
      lsu_valid_i = 0; lsu_addr_i = 0; lsu_data_i = 0;
      div_valid_i = 0; div_addr_i = 0; div_data_i = 0;
      jtag_req_i = 0; jtag_addr_i = 0; jtag_data_i = 0;
      busy_set_i = 0; busy_set_addr_i = 0; rs1_addr_i = 0; rs2_addr_i = 0;
      nc(); nc();
      // Reset state
      chk("rst_lsu_ready", lsu_ready_o, 1);
      chk("rst_div_ready", div_ready_o, 1);
      chk("rst_wr_en",     reg_wr_en_o, 0);
      chk("rst_ack",       jtag_ack_o,  0);
      chk("rst_hold",      alu_hold_o,  0);
      chk("rst_rs1_busy",  rs1_busy_o,  0);
      rst_n = 1'b1;
      nc();

      // 1: plain ALU write, latency 1
      alu_wr_en_i = 1; alu_wr_addr_i = 5; alu_wr_data_i = 32'h11;
      expq.push_back('{5'd5, 32'h11, 1'b0});
      nc(); alu_wr_en_i = 0;
      nc();

      // 2: scoreboard around an LSU write that loses to the ALU once
      busy_set_i = 1; busy_set_addr_i = 7; rs1_addr_i = 7;
      nc();
      chk("rs1_busy_after_set", rs1_busy_o, 1);
      busy_set_i = 0;
      lsu_valid_i = 1; lsu_addr_i = 7; lsu_data_i = 32'hAB;
      alu_wr_en_i = 1; alu_wr_addr_i = 3; alu_wr_data_i = 32'h33;
      expq.push_back('{5'd3, 32'h33, 1'b0});
      expq.push_back('{5'd7, 32'hAB, 1'b0});
      nc();
      chk("lsu_ready_full", lsu_ready_o, 0);
      chk("rs1_busy_pending", rs1_busy_o, 1);
      lsu_valid_i = 0; alu_wr_en_i = 0;
      nc();
      chk("rs1_busy_in_lsu_wr_cycle", rs1_busy_o, 1);
      nc();
      chk("rs1_busy_cleared", rs1_busy_o, 0);
      chk("lsu_ready_after_drain", lsu_ready_o, 1);

      // x0 is never marked busy
      busy_set_i = 1; busy_set_addr_i = 0; rs1_addr_i = 0;
      nc();
      busy_set_i = 0;
      chk("x0_never_busy", rs1_busy_o, 0);

      // 3: JTAG starved by back-to-back ALU writes
      jtag_req_i = 1; jtag_addr_i = 9; jtag_data_i = 32'h55;
      for (int i = 0; i < 3; i++) begin
         chk("hold_before_limit", alu_hold_o, 0);
         alu_wr_en_i = 1; alu_wr_addr_i = 1; alu_wr_data_i = 32'h100 + i;
         expq.push_back('{5'd1, 32'h100 + i, 1'b0});
         nc();
      end
      chk("hold_at_limit", alu_hold_o, 1);
      alu_wr_en_i = 0;
      expq.push_back('{5'd9, 32'h55, 1'b1});
      nc();
      chk("hold_one_cycle", alu_hold_o, 0);
      chk("jtag_ack_pulse", jtag_ack_o, 1);
      nc();               // blanking cycle, req still held
      chk("no_ack_in_blank", jtag_ack_o, 0);
      nc();
      jtag_req_i = 0;
      nc(); nc(); nc();

      // 4: LSU and DIV together, DIV targets x0
      chk("lsu_ready_idle", lsu_ready_o, 1);
      chk("div_ready_idle", div_ready_o, 1);
      lsu_valid_i = 1; lsu_addr_i = 10; lsu_data_i = 32'hA5;
      div_valid_i = 1; div_addr_i = 0;  div_data_i = 32'hD0;
      expq.push_back('{5'd10, 32'hA5, 1'b0});
      nc();
      chk("lsu_ready_captured", lsu_ready_o, 0);
      chk("div_ready_captured", div_ready_o, 0);
      lsu_valid_i = 0; div_valid_i = 0;
      nc();
      chk("div_ready_waiting", div_ready_o, 0);
      chk("lsu_ready_drained", lsu_ready_o, 1);
      nc();
      chk("div_ready_x0_drained", div_ready_o, 1);

      // 5: set and clear of x4 at the same edge
      rs2_addr_i = 4; busy_set_i = 1; busy_set_addr_i = 4;
      nc();
      chk("rs2_busy_set", rs2_busy_o, 1);
      busy_set_i = 0;
      lsu_valid_i = 1; lsu_addr_i = 4; lsu_data_i = 32'h44;
      expq.push_back('{5'd4, 32'h44, 1'b0});
      nc();
      lsu_valid_i = 0;
      nc();
      busy_set_i = 1; busy_set_addr_i = 4;   // LSU x4 on the port this cycle
      nc();
      busy_set_i = 0;
      chk("busy_set_wins", rs2_busy_o, 1);
      lsu_valid_i = 1; lsu_addr_i = 4; lsu_data_i = 32'h45;
      expq.push_back('{5'd4, 32'h45, 1'b0});
      nc();
      lsu_valid_i = 0;
      nc();
      chk("rs2_busy_in_wr_cycle", rs2_busy_o, 1);
      nc();
      chk("rs2_busy_cleared", rs2_busy_o, 0);

      // 6: reset with both slots full and JTAG pending
      lsu_valid_i = 1; lsu_addr_i = 11; lsu_data_i = 32'h61;
      div_valid_i = 1; div_addr_i = 12; div_data_i = 32'h62;
      busy_set_i = 1; busy_set_addr_i = 6; rs1_addr_i = 6;
      alu_wr_en_i = 1; alu_wr_addr_i = 2; alu_wr_data_i = 32'h22;
      jtag_req_i = 1; jtag_addr_i = 13; jtag_data_i = 32'h99;
      expq.push_back('{5'd2, 32'h22, 1'b0});
      nc();
      chk("pre_rst_lsu_full", lsu_ready_o, 0);
      chk("pre_rst_div_full", div_ready_o, 0);
      chk("pre_rst_busy6",    rs1_busy_o,  1);
      #2;
      rst_n = 1'b0;
      lsu_valid_i = 0; div_valid_i = 0; busy_set_i = 0; alu_wr_en_i = 0; jtag_req_i = 0;
      nc();
      chk("midrst_lsu_ready", lsu_ready_o, 1);
      chk("midrst_div_ready", div_ready_o, 1);
      chk("midrst_busy6",     rs1_busy_o,  0);
      chk("midrst_wr_en",     reg_wr_en_o, 0);
      rst_n = 1'b1;
      nc(); nc(); nc();
      chk("post_rst_lsu_ready", lsu_ready_o, 1);
      chk("post_rst_div_ready", div_ready_o, 1);
      chk("post_rst_busy6",     rs1_busy_o,  0);
      chk("post_rst_hold",      alu_hold_o,  0);

      // Requester re-issues after reset
      jtag_req_i = 1;
      expq.push_back('{5'd13, 32'h99, 1'b1});
      k = 0;
      nc();
      while (!jtag_ack_o && k < 10) begin
         nc();
         k++;
      end
      chk("jtag_reissue_ack", jtag_ack_o, 1);
      jtag_req_i = 0;
      nc(); nc(); nc(); nc();
      chk("queue_empty", expq.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
